// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the non-restoring signed divider:
//   DEFAULT_WIDTH : default operand/result width in bits
//   state_t       : controller states (IDLE, CALC, FIX, DONE)
// Optional feature macro used by the divider: DIVIDER_DBZ_EN.
// -----------------------------------------------------------------------------
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
// One combinational non-restoring division iteration on magnitudes.
// Ports:
//   rem_in  [WIDTH+1:0] : signed partial remainder before this iteration
//   q_in                : next dividend bit shifted in from the quotient register
//   dvs_mag [WIDTH-1:0] : divisor magnitude
//   rem_out [WIDTH+1:0] : signed partial remainder after this iteration
//   q_out               : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH+1:0] rem_in,
  input  logic             q_in,
  input  logic [WIDTH-1:0] dvs_mag,
  output logic [WIDTH+1:0] rem_out,
  output logic             q_out
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] dvs_ext_s;

  // Shift in the next dividend bit, then add or subtract the divisor depending
  // on the sign of the previous partial remainder. Two guard bits cover the
  // range [-2D, 2D) for a divisor magnitude of up to 2^(WIDTH-1).
  always_comb begin
    shifted_s = {rem_in[WIDTH:0], q_in};
    dvs_ext_s = {2'b00, dvs_mag};
    if (rem_in[WIDTH+1]) begin
      rem_out = shifted_s + dvs_ext_s;
    end else begin
      rem_out = shifted_s - dvs_ext_s;
    end
    // A non-negative result means the trial subtraction "fit".
    q_out = ~rem_out[WIDTH+1];
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// nonrestoring_divider
// Multi-cycle signed (truncating) divider using one non-restoring iteration
// per clock. Result appears WIDTH+1 edges after start is accepted.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   start     : request, only sampled in IDLE
//   dividend  : signed dividend, captured on accept
//   divisor   : signed divisor, captured on accept
//   busy      : high whenever the controller is not IDLE
//   valid     : one-cycle pulse with a new result
//   quotient  : signed quotient (held between results)
//   remainder : signed remainder, sign of dividend (held between results)
//   dbz       : (DIVIDER_DBZ_EN only) divide-by-zero flag, high with valid
// Macro DIVIDER_DBZ_EN: adds dbz and a short path for a zero divisor.
// -----------------------------------------------------------------------------
module nonrestoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVIDER_DBZ_EN
  ,
  output logic             dbz
`endif
);

  localparam int PW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t state_r, state_next;

  logic [PW-1:0]    rem_r;       // signed partial remainder
  logic [WIDTH-1:0] quo_r;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_mag_r;
  logic [WIDTH-1:0] dividend_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             dvs_zero_r;
`ifdef DIVIDER_DBZ_EN
  logic             dbz_pend_r;  // zero-divisor result still to be published
`endif

  logic [PW-1:0]    step_rem_s;
  logic             step_q_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH-1:0] rem_mag_s;
  logic [WIDTH-1:0] q_final_s;
  logic [WIDTH-1:0] r_final_s;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .q_in    (quo_r[WIDTH-1]),
    .dvs_mag (dvs_mag_r),
    .rem_out (step_rem_s),
    .q_out   (step_q_s)
  );

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    if (dividend[WIDTH-1]) begin
      dvd_mag_s = {WIDTH{1'b0}} - dividend;
    end else begin
      dvd_mag_s = dividend;
    end
    if (divisor[WIDTH-1]) begin
      dvs_mag_s = {WIDTH{1'b0}} - divisor;
    end else begin
      dvs_mag_s = divisor;
    end
  end

  // Remainder correction and sign fix-up; a zero divisor overrides both.
  always_comb begin
    // Only the low WIDTH bits matter: the corrected remainder is < divisor.
    if (rem_r[PW-1]) begin
      rem_mag_s = rem_r[WIDTH-1:0] + dvs_mag_r;
    end else begin
      rem_mag_s = rem_r[WIDTH-1:0];
    end
    if (dvs_zero_r) begin
      q_final_s = {WIDTH{1'b1}};
      r_final_s = dividend_r;
    end else begin
      if (neg_q_r) begin
        q_final_s = {WIDTH{1'b0}} - quo_r;
      end else begin
        q_final_s = quo_r;
      end
      if (neg_r_r) begin
        r_final_s = {WIDTH{1'b0}} - rem_mag_s;
      end else begin
        r_final_s = rem_mag_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
`ifdef DIVIDER_DBZ_EN
          if (divisor == {WIDTH{1'b0}}) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_CALC;
          end
`else
          state_next = ST_CALC;
`endif
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_next = ST_FIX;
        end else begin
          state_next = ST_CALC;
        end
      end
      ST_FIX: state_next = ST_DONE;
      ST_DONE: begin
`ifdef DIVIDER_DBZ_EN
        // Zero-divisor path spends one DONE cycle publishing its result.
        if (dbz_pend_r) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_IDLE;
        end
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_next;
      busy    <= (state_next != ST_IDLE);
    end
  end

  // Datapath: operand capture, iteration, result registers and valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r      <= '0;
      quo_r      <= '0;
      dvs_mag_r  <= '0;
      dividend_r <= '0;
      cnt_r      <= '0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dvs_zero_r <= 1'b0;
      valid      <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
`ifdef DIVIDER_DBZ_EN
      dbz_pend_r <= 1'b0;
      dbz        <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid <= 1'b0;
          if (start) begin
            rem_r      <= '0;
            quo_r      <= dvd_mag_s;
            dvs_mag_r  <= dvs_mag_s;
            dividend_r <= dividend;
            cnt_r      <= '0;
            neg_q_r    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_r    <= dividend[WIDTH-1];
            dvs_zero_r <= (divisor == {WIDTH{1'b0}});
`ifdef DIVIDER_DBZ_EN
            dbz_pend_r <= (divisor == {WIDTH{1'b0}});
`endif
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_CALC: begin
          rem_r <= step_rem_s;
          quo_r <= {quo_r[WIDTH-2:0], step_q_s};
          cnt_r <= cnt_r + CNT_ONE;
        end
        ST_FIX: begin
          quotient  <= q_final_s;
          remainder <= r_final_s;
          valid     <= 1'b1;
        end
        ST_DONE: begin
`ifdef DIVIDER_DBZ_EN
          if (dbz_pend_r) begin
            quotient   <= q_final_s;
            remainder  <= r_final_s;
            valid      <= 1'b1;
            dbz        <= 1'b1;
            dbz_pend_r <= 1'b0;
          end else begin
            valid <= 1'b0;
            dbz   <= 1'b0;
          end
`else
          valid <= 1'b0;
`endif
        end
        default: valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// tb_nonrestoring_divider
// Directed and random checks of nonrestoring_divider (WIDTH=8) against an
// integer-arithmetic reference. Honors DIVIDER_DBZ_EN when defined.
// -----------------------------------------------------------------------------
module tb_nonrestoring_divider;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef DIVIDER_DBZ_EN
  logic         dbz;
`endif

  int checks   = 0;
  int failures = 0;

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .valid     (valid),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIVIDER_DBZ_EN
    ,
    .dbz       (dbz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating integer division, zero divisor gives all-ones / dividend.
  function automatic void ref_div(input int a, input int b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    int qi;
    int ri;
    if (b == 0) begin
      q = {W{1'b1}};
      r = a[W-1:0];
    end else begin
      qi = a / b;
      ri = a % b;
      q = qi[W-1:0];
      r = ri[W-1:0];
    end
  endfunction

  function automatic int exp_latency(input int b);
`ifdef DIVIDER_DBZ_EN
    return (b == 0) ? 1 : W + 1;
`else
    return W + 1;
`endif
  endfunction

  // One operation: start at edge N, wait for valid, check timing and values.
  task automatic run_op(input int a, input int b, input string tag);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int lat;
    bit got;
    ref_div(a, b, eq, er);
    @(negedge clk);
    dividend = a[W-1:0];
    divisor  = b[W-1:0];
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = i;
        got = 1'b1;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_latency(b)));
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
`ifdef DIVIDER_DBZ_EN
    check({tag, "_dbz"}, 32'(dbz), 32'(b == 0));
`endif
    @(posedge clk);
    #1;
    check({tag, "_valid_pulse"}, 32'(valid), 32'd0);
    check({tag, "_hold_q"}, 32'(quotient), 32'(eq));
    check({tag, "_hold_r"}, 32'(remainder), 32'(er));
`ifdef DIVIDER_DBZ_EN
    check({tag, "_dbz_clr"}, 32'(dbz), 32'd0);
`endif
  endtask

  initial begin
    int a;
    int b;
    int nvalid;
    logic [W-1:0] cq;
    logic [W-1:0] cr;
    logic [W-1:0] eq;
    logic [W-1:0] er;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases, back-to-back.
    run_op(45, 10, "pos_pos");
    run_op(-45, 10, "neg_pos");
    run_op(45, -10, "pos_neg");
    run_op(-128, -1, "minneg_m1");
    run_op(127, 127, "max_max");
    run_op(7, 0, "div_zero");
    run_op(-7, 0, "neg_div_zero");
    run_op(-128, 1, "minneg_1");
    run_op(127, -128, "max_minneg");
    run_op(-128, -128, "minneg_minneg");

    // Random operands, occasionally a zero divisor.
    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      if (k % 8 == 3) begin
        b = 0;
      end
      run_op(a, b, "random");
    end

    // Start pulsed during CALC must be ignored.
    ref_div(100, 7, eq, er);
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    dividend = 8'hFD;
    divisor  = 8'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    nvalid = 0;
    cq     = '0;
    cr     = '0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        nvalid++;
        cq = quotient;
        cr = remainder;
      end
    end
    check("ignore_start_count", 32'(nvalid), 32'd1);
    check("ignore_start_q", 32'(cq), 32'(eq));
    check("ignore_start_r", 32'(cr), 32'(er));

    // Reset at N+4 (with start also high) abandons the operation.
    @(negedge clk);
    dividend = 8'd99;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_q", 32'(quotient), 32'd0);
    check("abort_r", 32'(remainder), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        nvalid++;
      end
    end
    check("abort_no_valid", 32'(nvalid), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    run_op(56, 79, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
